// File: rtl/btb_assoc_if.sv
// btb_assoc_if: fetch-lookup and execute-update bundle for the set-associative BTB.
interface btb_assoc_if;
  logic [31:0] pc_f;
  logic        hit_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        upd_valid_e;
  logic [31:0] pc_e;
  logic        taken_e;
  logic [31:0] target_e;
  logic        pred_taken_e;
  logic [31:0] pred_target_e;
  logic        mispredict_e;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
  modport master (
    output pc_f, upd_valid_e, pc_e, taken_e, target_e, pred_taken_e, pred_target_e,
    input  hit_f, pred_taken_f, pred_target_f, mispredict_e, perf_branches, perf_mispredicts
  );
  modport slave (
    input  pc_f, upd_valid_e, pc_e, taken_e, target_e, pred_taken_e, pred_target_e,
    output hit_f, pred_taken_f, pred_target_f, mispredict_e, perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/btb_assoc.sv
// btb_assoc: 2-way set-associative BTB with saturating counters, LRU and perf counters.
// Optional BTB_GSHARE_EN: direction from a GHR-xor-PC indexed pattern table instead of per-entry counters.
module btb_assoc #(
  parameter int SET_BITS = 4,
  parameter int TAG_BITS = 26,
  parameter int CTR_W    = 2
) (
  input logic       clk,
  input logic       rst,
  btb_assoc_if.slave bus
);
  localparam int SETS = 1 << SET_BITS;
  localparam logic [CTR_W-1:0] CMAX  = '1;
  localparam logic [CTR_W-1:0] CWEAK = CMAX ^ (CMAX >> 1);
  logic [SETS-1:0]     valid [2];
  logic [SETS-1:0]     lru;
  logic [TAG_BITS-1:0] tag   [2][SETS];
  logic [31:0]         tgt   [2][SETS];
  logic [CTR_W-1:0]    ctr   [2][SETS];
  logic [31:0]         perf_b, perf_m;
  logic [SET_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0] tag_f, tag_e;
  logic                hit0_f, hit1_f, way_f, dir_f;
  logic                hit0_e, hit1_e, hit_e, way_e, victim, mp;
  logic                unused_bits;
  function automatic logic [CTR_W-1:0] bump(input logic [CTR_W-1:0] c, input logic up);
    return up ? (c == CMAX ? c : c + CTR_W'(1)) : (c == '0 ? c : c - CTR_W'(1));
  endfunction
  always_comb begin
    idx_f  = bus.pc_f[SET_BITS+1:2];
    tag_f  = bus.pc_f[SET_BITS+2 +: TAG_BITS];
    idx_e  = bus.pc_e[SET_BITS+1:2];
    tag_e  = bus.pc_e[SET_BITS+2 +: TAG_BITS];
    hit0_f = valid[0][idx_f] && tag[0][idx_f] == tag_f;
    hit1_f = valid[1][idx_f] && tag[1][idx_f] == tag_f;
    way_f  = !hit0_f;
    hit0_e = valid[0][idx_e] && tag[0][idx_e] == tag_e;
    hit1_e = valid[1][idx_e] && tag[1][idx_e] == tag_e;
    hit_e  = hit0_e | hit1_e;
    way_e  = !hit0_e;
    // Fill invalid ways first (way 0 preferred) before evicting the LRU way.
    victim = !valid[0][idx_e] ? 1'b0 : !valid[1][idx_e] ? 1'b1 : lru[idx_e];
    mp     = bus.upd_valid_e & ((bus.pred_taken_e != bus.taken_e) |
             (bus.taken_e & (bus.pred_target_e != bus.target_e)));
  end
  assign unused_bits          = ^{bus.pc_f[1:0], bus.pc_e[1:0]};
  assign bus.hit_f            = hit0_f | hit1_f;
  assign bus.pred_taken_f     = bus.hit_f & dir_f;
  assign bus.pred_target_f    = bus.pred_taken_f ? tgt[way_f][idx_f] : bus.pc_f + 32'd4;
  assign bus.mispredict_e     = mp;
  assign bus.perf_branches    = perf_b;
  assign bus.perf_mispredicts = perf_m;
  always_ff @(posedge clk)
    if (!rst) begin
      for (int w = 0; w < 2; w++) begin
        valid[w] <= '0;
        for (int s = 0; s < SETS; s++) ctr[w][s] <= '0;
      end
      lru    <= '0;
      perf_b <= '0;
      perf_m <= '0;
    end else if (bus.upd_valid_e) begin
      perf_b <= perf_b + 32'd1;
      perf_m <= perf_m + (mp ? 32'd1 : 32'd0);
      if (hit_e) begin
        ctr[way_e][idx_e] <= bump(ctr[way_e][idx_e], bus.taken_e);
        if (bus.taken_e) tgt[way_e][idx_e] <= bus.target_e;
        lru[idx_e] <= !way_e;
      end else if (bus.taken_e) begin
        valid[victim][idx_e] <= 1'b1;
        tag[victim][idx_e]   <= tag_e;
        tgt[victim][idx_e]   <= bus.target_e;
        ctr[victim][idx_e]   <= CWEAK;
        lru[idx_e]           <= !victim;
      end
    end
`ifdef BTB_GSHARE_EN
  logic [SET_BITS-1:0] ghr;
  logic [CTR_W-1:0]    pht [SETS];
  assign dir_f = pht[idx_f ^ ghr][CTR_W-1];
  always_ff @(posedge clk)
    if (!rst) begin
      ghr <= '0;
      for (int s = 0; s < SETS; s++) pht[s] <= '0;
    end else if (bus.upd_valid_e) begin
      pht[idx_e ^ ghr] <= bump(pht[idx_e ^ ghr], bus.taken_e);
      ghr <= SET_BITS'({ghr, bus.taken_e});
    end
`else
  assign dir_f = ctr[way_f][idx_f][CTR_W-1];
`endif
endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: scoreboard bench for btb_assoc in its default configuration.
module tb_btb_assoc;
  typedef struct packed {
    logic [31:0] pc;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;
  typedef struct packed {
    logic        u;
    logic [31:0] pc;
    logic        t;
    logic [31:0] tgt;
    logic [31:0] lpc;
    logic        eh;
    logic        et;
    logic [31:0] etgt;
  } step_t;
  typedef struct packed {
    logic [31:0] pc;
    logic        t;
    logic [31:0] tgt;
    logic        pt;
    logic [31:0] ptgt;
    logic        emp;
  } br_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  btb_assoc_if bus();
  btb_assoc dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                     input logic pt, input logic [31:0] ptgt, output logic mp);
    @(negedge clk);
    bus.upd_valid_e   = 1'b1;
    bus.pc_e          = pc;
    bus.taken_e       = t;
    bus.target_e      = tgt;
    bus.pred_taken_e  = pt;
    bus.pred_target_e = ptgt;
    #1 mp = bus.mispredict_e;
    @(posedge clk);
    #1 bus.upd_valid_e = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset;
    exp_t e;
    rst = 1'b0;
    bus.upd_valid_e = 1'b0;
    bus.pc_e = '0; bus.taken_e = 1'b0; bus.target_e = '0;
    bus.pred_taken_e = 1'b0; bus.pred_target_e = '0;
    bus.pc_f = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back('{32'h100, 1'b0, 1'b0, 32'h104});
    e = sb.pop_front();
    bus.pc_f = e.pc;
    #1 checks++;
    if ({bus.hit_f, bus.pred_taken_f, bus.pred_target_f} !== {e.hit, e.taken, e.tgt}) begin
      errors++;
      $display("FAIL reset_lookup got hit=%b taken=%b tgt=%h want hit=%b taken=%b tgt=%h",
               bus.hit_f, bus.pred_taken_f, bus.pred_target_f, e.hit, e.taken, e.tgt);
    end
    checks++;
    if ({bus.perf_branches, bus.perf_mispredicts} !== 64'd0) begin
      errors++;
      $display("FAIL reset_perf got %0d/%0d want 0/0", bus.perf_branches, bus.perf_mispredicts);
    end
    rst = 1'b1;
  endtask

  task automatic run_steps(input string name, input step_t tbl[]);
    exp_t e;
    logic mp;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].u) upd(tbl[i].pc, tbl[i].t, tbl[i].tgt, 1'b0, 32'd0, mp);
      sb.push_back('{tbl[i].lpc, tbl[i].eh, tbl[i].et, tbl[i].etgt});
      e = sb.pop_front();
      bus.pc_f = e.pc;
      #1 checks++;
      if ({bus.hit_f, bus.pred_taken_f, bus.pred_target_f} !== {e.hit, e.taken, e.tgt}) begin
        errors++;
        $display("FAIL %s[%0d] pc=%h got hit=%b taken=%b tgt=%h want hit=%b taken=%b tgt=%h",
                 name, i, e.pc, bus.hit_f, bus.pred_taken_f, bus.pred_target_f, e.hit, e.taken, e.tgt);
      end
    end
  endtask

  task automatic test_counter;
    step_t tbl[] = '{
      '{1'b1, 32'h600, 1'b0, 32'h0,   32'h600, 1'b0, 1'b0, 32'h604},
      '{1'b1, 32'h100, 1'b1, 32'h200, 32'h100, 1'b1, 1'b1, 32'h200},
      '{1'b1, 32'h100, 1'b0, 32'h0,   32'h100, 1'b1, 1'b0, 32'h104},
      '{1'b1, 32'h100, 1'b0, 32'h0,   32'h100, 1'b1, 1'b0, 32'h104},
      '{1'b1, 32'h100, 1'b0, 32'h0,   32'h100, 1'b1, 1'b0, 32'h104},
      '{1'b1, 32'h100, 1'b1, 32'h200, 32'h100, 1'b1, 1'b0, 32'h104},
      '{1'b1, 32'h100, 1'b1, 32'h200, 32'h100, 1'b1, 1'b1, 32'h200}
    };
    do_reset();
    run_steps("counter", tbl);
  endtask

  task automatic test_saturate;
    step_t tbl[] = '{
      '{1'b1, 32'h100, 1'b1, 32'h210, 32'h100, 1'b1, 1'b1, 32'h210},
      '{1'b1, 32'h100, 1'b1, 32'h210, 32'h100, 1'b1, 1'b1, 32'h210},
      '{1'b1, 32'h100, 1'b1, 32'h210, 32'h100, 1'b1, 1'b1, 32'h210},
      '{1'b1, 32'h100, 1'b1, 32'h220, 32'h100, 1'b1, 1'b1, 32'h220},
      '{1'b1, 32'h100, 1'b0, 32'h0,   32'h100, 1'b1, 1'b1, 32'h220},
      '{1'b1, 32'h100, 1'b0, 32'h0,   32'h100, 1'b1, 1'b0, 32'h104}
    };
    run_steps("saturate", tbl);
  endtask

  task automatic test_lru;
    step_t tbl[] = '{
      '{1'b1, 32'h100, 1'b1, 32'h200, 32'h100, 1'b1, 1'b1, 32'h200},
      '{1'b1, 32'h140, 1'b1, 32'h240, 32'h140, 1'b1, 1'b1, 32'h240},
      '{1'b1, 32'h180, 1'b1, 32'h280, 32'h100, 1'b0, 1'b0, 32'h104},
      '{1'b0, 32'h0,   1'b0, 32'h0,   32'h140, 1'b1, 1'b1, 32'h240},
      '{1'b0, 32'h0,   1'b0, 32'h0,   32'h180, 1'b1, 1'b1, 32'h280},
      '{1'b1, 32'h140, 1'b1, 32'h244, 32'h140, 1'b1, 1'b1, 32'h244},
      '{1'b1, 32'h1c0, 1'b1, 32'h2c0, 32'h180, 1'b0, 1'b0, 32'h184},
      '{1'b0, 32'h0,   1'b0, 32'h0,   32'h1c0, 1'b1, 1'b1, 32'h2c0},
      '{1'b0, 32'h0,   1'b0, 32'h0,   32'h140, 1'b1, 1'b1, 32'h244},
      '{1'b1, 32'h104, 1'b1, 32'h300, 32'h104, 1'b1, 1'b1, 32'h300},
      '{1'b0, 32'h0,   1'b0, 32'h0,   32'h140, 1'b1, 1'b1, 32'h244}
    };
    do_reset();
    run_steps("lru", tbl);
  endtask

  task automatic test_back_to_back;
    step_t tbl[] = '{
      '{1'b0, 32'h0,   1'b0, 32'h0,   32'h300, 1'b1, 1'b1, 32'h380},
      '{1'b1, 32'h300, 1'b0, 32'h0,   32'h300, 1'b1, 1'b1, 32'h380}
    };
    do_reset();
    @(negedge clk);
    bus.upd_valid_e = 1'b1;
    bus.pc_e = 32'h300; bus.taken_e = 1'b1; bus.target_e = 32'h380;
    bus.pc_f = 32'h300;
    #1 checks++;
    if (bus.hit_f !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass got hit=%b want 0", bus.hit_f);
    end
    @(posedge clk);
    #1 checks++;
    if ({bus.hit_f, bus.pred_target_f} !== {1'b1, 32'h380}) begin
      errors++;
      $display("FAIL b2b_mid got hit=%b tgt=%h want hit=1 tgt=00000380", bus.hit_f, bus.pred_target_f);
    end
    @(posedge clk);
    #1 bus.upd_valid_e = 1'b0;
    run_steps("b2b", tbl);
  endtask

  task automatic test_mispredict_perf;
    br_t tbl[] = '{
      '{32'h100, 1'b1, 32'h300, 1'b1, 32'h200, 1'b1},
      '{32'h100, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0},
      '{32'h104, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0},
      '{32'h108, 1'b0, 32'h0,   1'b1, 32'h200, 1'b1},
      '{32'h10c, 1'b1, 32'h400, 1'b0, 32'h0,   1'b1},
      '{32'h110, 1'b0, 32'h999, 1'b0, 32'h123, 1'b0},
      '{32'h114, 1'b1, 32'h500, 1'b1, 32'h500, 1'b0},
      '{32'h118, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0},
      '{32'h11c, 1'b1, 32'h600, 1'b1, 32'h600, 1'b0},
      '{32'h120, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0}
    };
    logic mp;
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      upd(tbl[i].pc, tbl[i].t, tbl[i].tgt, tbl[i].pt, tbl[i].ptgt, mp);
      checks++;
      if (mp !== tbl[i].emp) begin
        errors++;
        $display("FAIL mispredict[%0d] got %b want %b", i, mp, tbl[i].emp);
      end
    end
    @(negedge clk);
    bus.pred_taken_e = 1'b1; bus.taken_e = 1'b0;
    #1 checks++;
    if (bus.mispredict_e !== 1'b0) begin
      errors++;
      $display("FAIL mispredict_idle got %b want 0", bus.mispredict_e);
    end
    @(posedge clk);
    #1 checks++;
    if ({bus.perf_branches, bus.perf_mispredicts} !== {32'd10, 32'd3}) begin
      errors++;
      $display("FAIL perf got %0d/%0d want 10/3", bus.perf_branches, bus.perf_mispredicts);
    end
  endtask

  task automatic test_reset_midstream;
    exp_t e;
    logic mp;
    upd(32'h700, 1'b1, 32'h780, 1'b0, 32'h0, mp);
    @(negedge clk);
    rst = 1'b0;
    bus.upd_valid_e = 1'b1;
    bus.pc_e = 32'h740; bus.taken_e = 1'b1; bus.target_e = 32'h800;
    @(posedge clk);
    #1 rst = 1'b1;
    bus.upd_valid_e = 1'b0;
    sb.push_back('{32'h700, 1'b0, 1'b0, 32'h704});
    sb.push_back('{32'h740, 1'b0, 1'b0, 32'h744});
    sb.push_back('{32'h100, 1'b0, 1'b0, 32'h104});
    sb.push_back('{32'h114, 1'b0, 1'b0, 32'h118});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.pc_f = e.pc;
      #1 checks++;
      if ({bus.hit_f, bus.pred_taken_f, bus.pred_target_f} !== {e.hit, e.taken, e.tgt}) begin
        errors++;
        $display("FAIL midreset pc=%h got hit=%b taken=%b tgt=%h want hit=%b taken=%b tgt=%h",
                 e.pc, bus.hit_f, bus.pred_taken_f, bus.pred_target_f, e.hit, e.taken, e.tgt);
      end
    end
    checks++;
    if ({bus.perf_branches, bus.perf_mispredicts} !== 64'd0) begin
      errors++;
      $display("FAIL midreset_perf got %0d/%0d want 0/0", bus.perf_branches, bus.perf_mispredicts);
    end
  endtask

  initial begin
    test_reset();
    test_counter();
    test_saturate();
    test_lru();
    test_back_to_back();
    test_mispredict_perf();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
